// File: rtl/wb_cmd_master_if.sv
// Classic Wishbone bus bundle shared by the command master
// and the register slaves it drives.
interface wishbone #(
   parameter int ADR_BITS    = 16,
   parameter int PORT_SIZE   = 32,
   parameter int GRANULARITY = 8
);
   localparam int SEL_W = PORT_SIZE / GRANULARITY;

   logic                 cyc;
   logic                 stb;
   logic                 we;
   logic [ADR_BITS-1:0]  adr;
   logic [SEL_W-1:0]     sel;
   logic [PORT_SIZE-1:0] dat_ms;
   logic [PORT_SIZE-1:0] dat_sm;
   logic                 ack;
   logic                 err;
   logic                 rty;

   modport master (
      output cyc, stb, we, adr, sel, dat_ms,
      input  dat_sm, ack, err, rty
   );

   modport slave (
      input  cyc, stb, we, adr, sel, dat_ms,
      output dat_sm, ack, err, rty
   );
endinterface

// File: rtl/wb_cmd_master.sv
// Command stream to classic Wishbone single-cycle master,
// with bounded retry, per-attempt timeout and one response per command.
module wb_cmd_master #(
   parameter int ADR_BITS       = 16,
   parameter int PORT_SIZE      = 32,
   parameter int GRANULARITY    = 8,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int MAX_RETRIES    = 3,
   localparam int SEL_W         = PORT_SIZE / GRANULARITY
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [ADR_BITS-1:0]  cmd_adr_i,
   input  logic                 cmd_we_i,
   input  logic [SEL_W-1:0]     cmd_sel_i,
   input  logic [PORT_SIZE-1:0] cmd_dat_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [PORT_SIZE-1:0] rsp_dat_o,
   output logic [1:0]           rsp_status_o,
   wishbone.master              wb
);
   localparam int RC_W = (MAX_RETRIES > 0) ?
                         $clog2(MAX_RETRIES + 1) : 1;
   localparam int TC_W = (TIMEOUT_CYCLES > 0) ?
                         $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [RC_W-1:0] RTY_MAX = RC_W'(MAX_RETRIES);
   localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [TC_W-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ?
                                         TC_W'(TIMEOUT_CYCLES - 1) : '0;

   localparam logic [1:0] ST_OK  = 2'b00;
   localparam logic [1:0] ST_ERR = 2'b01;
   localparam logic [1:0] ST_TMO = 2'b10;
   localparam logic [1:0] ST_RTY = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUS,
      S_GAP,
      S_RESP
   } state_t;

   state_t               r_state;
   state_t               w_state_nx;
   logic                 r_cyc;
   logic                 r_rsp_valid;
   logic                 r_cmd_ready;
   logic                 w_load;
   logic [ADR_BITS-1:0]  r_adr;
   logic                 r_we;
   logic [SEL_W-1:0]     r_sel;
   logic [PORT_SIZE-1:0] r_dat;
   logic [RC_W-1:0]      r_rty;
   logic [RC_W-1:0]      w_rty_nx;
   logic [TC_W-1:0]      r_to;
   logic [TC_W-1:0]      w_to_nx;
   logic [PORT_SIZE-1:0] r_rsp_dat;
   logic [PORT_SIZE-1:0] w_rsp_dat_nx;
   logic [1:0]           r_rsp_st;
   logic [1:0]           w_rsp_st_nx;
   logic                 w_to_hit;
   logic                 w_rty_left;

   // r_to counts completed BUS cycles before the current one,
   // so the last allowed cycle is TIMEOUT_CYCLES-1.
   assign w_to_hit   = TO_EN && (r_to == TO_LAST);
   assign w_rty_left = (r_rty < RTY_MAX);

   // Next state, counters and response capture
   always_comb begin
      w_state_nx   = r_state;
      w_rty_nx     = r_rty;
      w_to_nx      = r_to;
      w_rsp_dat_nx = r_rsp_dat;
      w_rsp_st_nx  = r_rsp_st;
      w_load       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (cmd_valid_i && r_cmd_ready) begin
               w_load     = 1'b1;
               w_rty_nx   = '0;
               w_to_nx    = '0;
               w_state_nx = S_BUS;
            end
         end
         S_BUS: begin
            if (r_to != {TC_W{1'b1}}) begin
               w_to_nx = r_to + 1'b1;
            end
            if (wb.ack) begin
               w_rsp_st_nx  = ST_OK;
               w_rsp_dat_nx = r_we ? '0 : wb.dat_sm;
               w_state_nx   = S_RESP;
            end else if (wb.err) begin
               w_rsp_st_nx  = ST_ERR;
               w_rsp_dat_nx = '0;
               w_state_nx   = S_RESP;
            end else if (wb.rty) begin
               if (w_rty_left) begin
                  w_rty_nx   = r_rty + 1'b1;
                  w_state_nx = S_GAP;
               end else begin
                  w_rsp_st_nx  = ST_RTY;
                  w_rsp_dat_nx = '0;
                  w_state_nx   = S_RESP;
               end
            end else if (w_to_hit) begin
               w_rsp_st_nx  = ST_TMO;
               w_rsp_dat_nx = '0;
               w_state_nx   = S_RESP;
            end
         end
         S_GAP: begin
            w_to_nx    = '0;
            w_state_nx = S_BUS;
         end
         S_RESP: begin
            if (rsp_ready_i) begin
               w_state_nx = S_IDLE;
            end
         end
      endcase
   end

   // State, counters and registered control outputs
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state     <= S_IDLE;
         r_cyc       <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_cmd_ready <= 1'b0;
         r_rty       <= '0;
         r_to        <= '0;
         r_rsp_dat   <= '0;
         r_rsp_st    <= ST_OK;
      end else begin
         r_state     <= w_state_nx;
         r_cyc       <= (w_state_nx == S_BUS);
         r_rsp_valid <= (w_state_nx == S_RESP);
         r_cmd_ready <= (w_state_nx == S_IDLE);
         r_rty       <= w_rty_nx;
         r_to        <= w_to_nx;
         r_rsp_dat   <= w_rsp_dat_nx;
         r_rsp_st    <= w_rsp_st_nx;
      end
   end

   // Command capture; held for every attempt of the transaction
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_adr <= '0;
         r_we  <= 1'b0;
         r_sel <= '0;
         r_dat <= '0;
      end else if (w_load) begin
         r_adr <= cmd_adr_i;
         r_we  <= cmd_we_i;
         r_sel <= cmd_sel_i;
         r_dat <= cmd_dat_i;
      end
   end

   assign cmd_ready_o  = r_cmd_ready;
   assign rsp_valid_o  = r_rsp_valid;
   assign rsp_dat_o    = r_rsp_dat;
   assign rsp_status_o = r_rsp_st;
   assign wb.cyc       = r_cyc;
   assign wb.stb       = r_cyc;
   assign wb.we        = r_we;
   assign wb.adr       = r_adr;
   assign wb.sel       = r_sel;
   assign wb.dat_ms    = r_dat;
endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: vector table,
// hand sequences for reset, and random commands against a model.
`timescale 1ns/1ps
module tb_wb_cmd_master;
   localparam int AW = 16, DW = 32, GR = 8, SW = 4;
   localparam int TMO = 255, RTY = 3;
   localparam int KACK = 0, KERR = 1, KRTY = 2;
   localparam int KNONE = 3, KAE = 4, KER = 5;

   typedef struct {
      logic [15:0] adr;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic [31:0] sdat;
      int          k0, w0, k1, w1, k2, w2;
      int          hold;
      bit          late;
      logic [1:0]  est;
      logic [31:0] edat;
      int          np, nc, lat;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [AW-1:0] cmd_adr = '0;
   logic          cmd_we = 1'b0;
   logic [SW-1:0] cmd_sel = '0;
   logic [DW-1:0] cmd_dat = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_dat;
   logic [1:0]    rsp_status;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wishbone #(AW, DW, GR) wb ();

   wb_cmd_master #(
      .ADR_BITS(AW), .PORT_SIZE(DW), .GRANULARITY(GR),
      .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(RTY)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_adr_i(cmd_adr), .cmd_we_i(cmd_we),
      .cmd_sel_i(cmd_sel), .cmd_dat_i(cmd_dat),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_dat_o(rsp_dat), .rsp_status_o(rsp_status),
      .wb(wb)
   );

   vec_t cur;
   int   s_att, s_cnt;
   int   m_pulses, m_cyc, m_gap, m_gaperr, m_stab;
   bit   m_prev = 1'b0;

   // Scripted slave plus bus monitor, on the falling edge
   always @(negedge clk) begin
      int k, w;
      bit hit;
      wb.dat_sm = cur.sdat;
      if (wb.cyc) begin
         if (!m_prev) begin
            if (m_pulses > 0 && m_gap != 1) m_gaperr++;
            m_pulses++;
            s_cnt = 0;
         end
         m_cyc++;
         s_cnt++;
         if (wb.adr !== cur.adr || wb.we !== cur.we ||
             wb.sel !== cur.sel || wb.dat_ms !== cur.dat ||
             wb.stb !== 1'b1 || cmd_ready !== 1'b0)
            m_stab++;
         k = (s_att == 0) ? cur.k0 : (s_att == 1) ? cur.k1 : cur.k2;
         w = (s_att == 0) ? cur.w0 : (s_att == 1) ? cur.w1 : cur.w2;
         hit = (s_cnt == w + 1);
         wb.ack = hit && (k == KACK || k == KAE);
         wb.err = hit && (k == KERR || k == KAE || k == KER);
         wb.rty = hit && (k == KRTY || k == KER);
      end else begin
         if (m_prev) begin
            s_att++;
            m_gap = 0;
         end
         m_gap++;
         if (wb.stb !== 1'b0) m_stab++;
         wb.ack = cur.late;
         wb.err = 1'b0;
         wb.rty = 1'b0;
      end
      m_prev = wb.cyc;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   // Expected result from the retry/timeout rules, attempt by attempt
   function automatic void model(input vec_t v, output logic [1:0] st,
                                 output logic [31:0] d, output int np,
                                 output int nc, output int lat);
      int a, r, k, w;
      bit done;
      np = 0; nc = 0; r = 0; a = 0; st = 2'b00; d = '0; done = 1'b0;
      while (!done) begin
         k = (a == 0) ? v.k0 : (a == 1) ? v.k1 : v.k2;
         w = (a == 0) ? v.w0 : (a == 1) ? v.w1 : v.w2;
         np++;
         if (k == KNONE || w + 1 > TMO) begin
            nc += TMO; st = 2'b10; done = 1'b1;
         end else begin
            nc += w + 1;
            if (k == KACK || k == KAE) begin
               st = 2'b00; d = v.we ? 32'h0 : v.sdat; done = 1'b1;
            end else if (k == KERR || k == KER) begin
               st = 2'b01; done = 1'b1;
            end else if (r < RTY) begin
               r++; a++;
            end else begin
               st = 2'b11; done = 1'b1;
            end
         end
      end
      lat = nc + (np - 1) + 1;
   endfunction

   task automatic issue(input vec_t v, output bit acc);
      int n;
      cur = v;
      m_pulses = 0; m_cyc = 0; s_att = 0;
      m_gaperr = 0; m_stab = 0;
      @(negedge clk);
      cmd_adr = v.adr; cmd_we = v.we;
      cmd_sel = v.sel; cmd_dat = v.dat;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      acc = cmd_ready;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic exec(input string nm, input vec_t v);
      bit          acc;
      int          lat, herr;
      logic [1:0]  st;
      logic [31:0] d;
      issue(v, acc);
      chk({nm, " accept"}, 32'(acc), 32'd1);
      lat = 1;
      while (!rsp_valid && lat < 3000) begin
         @(negedge clk);
         lat++;
      end
      chk({nm, " rsp_seen"}, 32'(rsp_valid), 32'd1);
      chk({nm, " status"}, 32'(rsp_status), 32'(v.est));
      chk({nm, " data"}, rsp_dat, v.edat);
      chk({nm, " stb_pulses"}, 32'(m_pulses), 32'(v.np));
      chk({nm, " cyc_cycles"}, 32'(m_cyc), 32'(v.nc));
      chk({nm, " latency"}, 32'(lat), 32'(v.lat));
      chk({nm, " gap_err"}, 32'(m_gaperr), 32'd0);
      chk({nm, " bus_stable_err"}, 32'(m_stab), 32'd0);
      st = rsp_status; d = rsp_dat; herr = 0;
      for (int i = 0; i < v.hold; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_status !== st ||
             rsp_dat !== d || cmd_ready !== 1'b0 || wb.cyc !== 1'b0)
            herr++;
      end
      chk({nm, " hold_err"}, 32'(herr), 32'd0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({nm, " rsp_valid_after"}, 32'(rsp_valid), 32'd0);
      chk({nm, " ready_after"}, 32'(cmd_ready), 32'd1);
      chk({nm, " pulses_after"}, 32'(m_pulses), 32'(v.np));
   endtask

   vec_t tbl[12];
   vec_t v;

   initial begin
      int bad;
      int k;
      tbl[0]  = '{16'h0012, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF,
                  KACK, 1, KACK, 1, KACK, 1, 0, 1'b0,
                  2'b00, 32'hDEADBEEF, 1, 2, 3};
      tbl[1]  = '{16'h0100, 1'b0, 4'hF, 32'h0, 32'h12345678,
                  KACK, 0, KACK, 0, KACK, 0, 0, 1'b0,
                  2'b00, 32'h12345678, 1, 1, 2};
      tbl[2]  = '{16'h0040, 1'b1, 4'h3, 32'hA5A50001, 32'h77777777,
                  KACK, 0, KACK, 0, KACK, 0, 5, 1'b0,
                  2'b00, 32'h0, 1, 1, 2};
      tbl[3]  = '{16'h0200, 1'b0, 4'hF, 32'h0, 32'hCAFEF00D,
                  KAE, 2, KAE, 2, KAE, 2, 1, 1'b0,
                  2'b00, 32'hCAFEF00D, 1, 3, 4};
      tbl[4]  = '{16'h0201, 1'b0, 4'h1, 32'h0, 32'h11112222,
                  KERR, 0, KERR, 0, KERR, 0, 0, 1'b0,
                  2'b01, 32'h0, 1, 1, 2};
      tbl[5]  = '{16'h0300, 1'b1, 4'hC, 32'h00C0FFEE, 32'h0,
                  KRTY, 0, KRTY, 0, KRTY, 0, 0, 1'b0,
                  2'b11, 32'h0, 4, 4, 8};
      tbl[6]  = '{16'h0301, 1'b0, 4'hF, 32'h0, 32'h0BADF00D,
                  KRTY, 0, KRTY, 0, KACK, 0, 0, 1'b0,
                  2'b00, 32'h0BADF00D, 3, 3, 6};
      tbl[7]  = '{16'h0400, 1'b0, 4'hF, 32'h0, 32'h55AA55AA,
                  KNONE, 0, KNONE, 0, KNONE, 0, 4, 1'b1,
                  2'b10, 32'h0, 1, 255, 256};
      tbl[8]  = '{16'h0401, 1'b0, 4'hF, 32'h0, 32'h1,
                  KRTY, 1, KNONE, 0, KNONE, 0, 0, 1'b0,
                  2'b10, 32'h0, 2, 257, 259};
      tbl[9]  = '{16'hFFFF, 1'b1, 4'hF, 32'hFFFFFFFF, 32'h0,
                  KERR, 3, KERR, 3, KERR, 3, 2, 1'b0,
                  2'b01, 32'h0, 1, 4, 5};
      tbl[10] = '{16'h0500, 1'b0, 4'hF, 32'h0, 32'h89ABCDEF,
                  KER, 0, KER, 0, KER, 0, 0, 1'b0,
                  2'b01, 32'h0, 1, 1, 2};
      tbl[11] = '{16'h0501, 1'b0, 4'h6, 32'h0, 32'h13579BDF,
                  KRTY, 2, KACK, 2, KACK, 2, 0, 1'b0,
                  2'b00, 32'h13579BDF, 2, 6, 8};

      repeat (3) @(negedge clk);
      chk("rst cyc_stb_we", {29'h0, wb.cyc, wb.stb, wb.we}, 32'h0);
      chk("rst adr", 32'(wb.adr), 32'h0);
      chk("rst sel", 32'(wb.sel), 32'h0);
      chk("rst dat_ms", wb.dat_ms, 32'h0);
      chk("rst rsp", {29'h0, rsp_valid, rsp_status}, 32'h0);
      chk("rst rsp_dat", rsp_dat, 32'h0);
      chk("rst cmd_ready", 32'(cmd_ready), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst cmd_ready", 32'(cmd_ready), 32'h1);

      for (int i = 0; i < 12; i++)
         exec($sformatf("vec%0d", i), tbl[i]);

      v = tbl[7];
      v.late = 1'b0;
      cur = v;
      @(negedge clk);
      cmd_adr = 16'h0777; cmd_we = 1'b0; cmd_sel = 4'hF;
      cmd_dat = 32'h0; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("midbus cyc_before", 32'(wb.cyc), 32'h1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midbus cyc_stb_drop", {30'h0, wb.cyc, wb.stb}, 32'h0);
      chk("midbus rsp_ready_low", {30'h0, rsp_valid, cmd_ready}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || wb.cyc !== 1'b0) bad++;
      end
      chk("midbus no_rsp", 32'(bad), 32'h0);
      chk("midbus cmd_ready", 32'(cmd_ready), 32'h1);
      exec("after_rst", tbl[0]);

      for (int n = 0; n < 30; n++) begin
         v.adr  = 16'($urandom);
         v.we   = 1'($urandom);
         v.sel  = 4'($urandom);
         v.dat  = $urandom;
         v.sdat = $urandom;
         for (int a = 0; a < 3; a++) begin
            k = int'($urandom_range(0, 9));
            k = (k < 3) ? KACK : (k == 3) ? KERR : (k < 7) ? KRTY :
                (k == 7) ? KAE : (k == 8) ? KER :
                ($urandom_range(0, 3) == 0) ? KNONE : KACK;
            if (a == 0) begin
               v.k0 = k; v.w0 = int'($urandom_range(0, 3));
            end else if (a == 1) begin
               v.k1 = k; v.w1 = int'($urandom_range(0, 3));
            end else begin
               v.k2 = k; v.w2 = int'($urandom_range(0, 3));
            end
         end
         v.hold = int'($urandom_range(0, 2));
         v.late = 1'($urandom);
         model(v, v.est, v.edat, v.np, v.nc, v.lat);
         exec($sformatf("rnd%0d", n), v);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
